// File: rtl/arbitro_memoria_datos.sv
// Round-robin arbiter between the CPU MEM stage (A) and the loader/debug port (B)
// in front of the word-indexed data memory: one strobe cycle per access, then an Ack/Err pulse.
module arbitro_memoria_datos #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req_A,
    input  logic          We_A,
    input  logic [31:0]   Addr_A,
    input  logic [31:0]   WData_A,
    output logic          Ack_A,
    output logic [31:0]   RData_A,
    input  logic          Req_B,
    input  logic          We_B,
    input  logic [31:0]   Addr_B,
    input  logic [31:0]   WData_B,
    output logic          Ack_B,
    output logic [31:0]   RData_B,
    output logic          Err,
    output logic [AW-1:0] Mem_Adress,
    output logic [31:0]   Mem_Write_Data,
    output logic          Mem_Write,
    output logic          Mem_Read,
    input  logic [31:0]   Mem_Read_Data,
    output logic [CW-1:0] Num_Accesos
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;   // 0 = A, 1 = B
    logic          gnt_q, gnt_d;
    logic          lat_we_q, lat_we_d;
    logic          lat_bad_q, lat_bad_d;
    logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_q, err_d;
    logic [31:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic [AW-1:0] mem_adress_q, mem_adress_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_a_eff, req_b_eff, win_b, sel_we, sel_bad;
    logic [31:0]   sel_addr, sel_wdata;

    always_comb begin
        // The port being acknowledged in RESP is dropping its request, so it cannot re-win.
        req_a_eff = Req_A && !(state_q == RESP && !gnt_q);
        req_b_eff = Req_B && !(state_q == RESP &&  gnt_q);
        win_b     = req_b_eff && (!req_a_eff || !last_gnt_q);
        sel_we    = win_b ? We_B    : We_A;
        sel_addr  = win_b ? Addr_B  : Addr_A;
        sel_wdata = win_b ? WData_B : WData_A;
        sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));

        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        gnt_d        = gnt_q;
        lat_we_d     = lat_we_q;
        lat_bad_d    = lat_bad_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        err_d        = 1'b0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        mem_adress_d = mem_adress_q;
        mem_wdata_d  = mem_wdata_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        cnt_d        = cnt_q;

        case (state_q)
            ACCESS: begin
                state_d = RESP;
                ack_a_d = !gnt_q;
                ack_b_d = gnt_q;
                err_d   = lat_bad_q;
                if (lat_bad_q) begin
                    if (gnt_q) rdata_b_d = 32'd0;
                    else       rdata_a_d = 32'd0;
                end else begin
                    if (!lat_we_q) begin
                        if (gnt_q) rdata_b_d = Mem_Read_Data;
                        else       rdata_a_d = Mem_Read_Data;
                    end
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (req_a_eff || req_b_eff) begin
                    state_d      = ACCESS;
                    gnt_d        = win_b;
                    last_gnt_d   = win_b;
                    lat_we_d     = sel_we;
                    lat_bad_d    = sel_bad;
                    mem_adress_d = sel_addr[AW+1:2];
                    if (!sel_bad && sel_we) mem_wdata_d = sel_wdata;
                    mem_write_d  = !sel_bad && sel_we;
                    mem_read_d   = !sel_bad && !sel_we;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            gnt_q        <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_bad_q    <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_a_q    <= 32'd0;
            rdata_b_q    <= 32'd0;
            mem_adress_q <= '0;
            mem_wdata_q  <= 32'd0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            gnt_q        <= gnt_d;
            lat_we_q     <= lat_we_d;
            lat_bad_q    <= lat_bad_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            err_q        <= err_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            mem_adress_q <= mem_adress_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            cnt_q        <= cnt_d;
        end
    end

    assign Ack_A          = ack_a_q;
    assign Ack_B          = ack_b_q;
    assign Err            = err_q;
    assign RData_A        = rdata_a_q;
    assign RData_B        = rdata_b_q;
    assign Mem_Adress     = mem_adress_q;
    assign Mem_Write_Data = mem_wdata_q;
    assign Mem_Write      = mem_write_q;
    assign Mem_Read       = mem_read_q;
    assign Num_Accesos    = cnt_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed and randomized transactions against a transaction-level model of the
// arbiter, with a combinational 32-word memory stub behind the DUT.
module tb_arbitro_memoria_datos;

    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Req_A = 1'b0, We_A = 1'b0, Req_B = 1'b0, We_B = 1'b0;
    logic [31:0]   Addr_A = '0, WData_A = '0, Addr_B = '0, WData_B = '0;
    logic          Ack_A, Ack_B, Err, Mem_Write, Mem_Read;
    logic [31:0]   RData_A, RData_B, Mem_Write_Data, Mem_Read_Data;
    logic [4:0]    Mem_Adress;
    logic [CW-1:0] Num_Accesos;

    arbitro_memoria_datos #(.DEPTH(32), .AW(5), .CW(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req_A(Req_A), .We_A(We_A), .Addr_A(Addr_A), .WData_A(WData_A),
        .Ack_A(Ack_A), .RData_A(RData_A),
        .Req_B(Req_B), .We_B(We_B), .Addr_B(Addr_B), .WData_B(WData_B),
        .Ack_B(Ack_B), .RData_B(RData_B),
        .Err(Err), .Mem_Adress(Mem_Adress), .Mem_Write_Data(Mem_Write_Data),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Mem_Read_Data(Mem_Read_Data),
        .Num_Accesos(Num_Accesos)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:31];
    always @(posedge Clk) if (Mem_Write) mem[Mem_Adress] <= Mem_Write_Data;
    assign Mem_Read_Data = mem[Mem_Adress];

    // Reference model state
    logic [31:0] ref_mem [0:31];
    logic [31:0] exp_rd [0:1];
    int          exp_cnt = 0;
    bit          lg = 1'b1;   // last granted port: 0 = A, 1 = B
    int          vectors = 0;
    int          errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr / 4 >= 32);
    endfunction

    function automatic int sat_inc(input int c);
        return (c < (1 << CW) - 1) ? c + 1 : c;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack_a"}, 32'(Ack_A), 32'd0);
        chk({tag, "_ack_b"}, 32'(Ack_B), 32'd0);
        chk({tag, "_strobes"}, 32'({Mem_Write, Mem_Read}), 32'd0);
    endtask

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (!p) begin Req_A = req; We_A = we; Addr_A = addr; WData_A = wd; end
        else    begin Req_B = req; We_B = we; Addr_B = addr; WData_B = wd; end
    endtask

    // One isolated access on port p; checks ACCESS strobes, RESP handshake, counter.
    task automatic txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        bit bad;
        int idx;
        bad = is_bad(addr);
        idx = int'(addr / 4) % 32;
        @(negedge Clk);
        drive(p, 1'b1, we, addr, wd);
        @(negedge Clk);
        chk("acc_write", 32'(Mem_Write), 32'(!bad && we));
        chk("acc_read",  32'(Mem_Read),  32'(!bad && !we));
        if (!bad) chk("acc_index", 32'(Mem_Adress), 32'(idx));
        if (!bad && we) chk("acc_wdata", Mem_Write_Data, wd);
        if (bad) exp_rd[p] = 32'd0;
        else begin
            if (we) ref_mem[idx] = wd;
            else    exp_rd[p] = ref_mem[idx];
            exp_cnt = sat_inc(exp_cnt);
        end
        lg = p;
        drive(p, 1'b1, $urandom_range(0, 1), $urandom, $urandom);  // fields must be latched
        @(negedge Clk);
        chk("resp_ack_a", 32'(Ack_A), 32'(p == 1'b0));
        chk("resp_ack_b", 32'(Ack_B), 32'(p == 1'b1));
        chk("resp_err", 32'(Err), 32'(bad));
        chk("resp_rdata_a", RData_A, exp_rd[0]);
        chk("resp_rdata_b", RData_B, exp_rd[1]);
        chk("resp_strobes", 32'({Mem_Write, Mem_Read}), 32'd0);
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge Clk);
        chk_idle_outputs("post");
        chk("post_count", 32'(Num_Accesos), 32'(exp_cnt));
    endtask

    // Both ports hold read requests until n accesses have completed.
    task automatic both_reads(input int n);
        logic [31:0] addr [0:1];
        bit w;
        addr[0] = 32'($urandom_range(0, 31)) * 4;
        addr[1] = 32'($urandom_range(0, 31)) * 4;
        @(negedge Clk);
        drive(1'b0, 1'b1, 1'b0, addr[0], 32'd0);
        drive(1'b1, 1'b1, 1'b0, addr[1], 32'd0);
        w = !lg;
        for (int k = 1; k <= 2 * n; k++) begin
            @(negedge Clk);
            chk("rr_not_both_strobes", 32'(Mem_Write && Mem_Read), 32'd0);
            if (k % 2 == 1) begin
                chk("rr_acc_read", 32'(Mem_Read), 32'd1);
                chk("rr_acc_index", 32'(Mem_Adress), addr[w] / 4);
                chk("rr_acc_noack", 32'({Ack_A, Ack_B}), 32'd0);
                exp_rd[w] = ref_mem[addr[w] / 4];
                exp_cnt = sat_inc(exp_cnt);
                lg = w;
            end else begin
                chk("rr_ack_a", 32'(Ack_A), 32'(w == 1'b0));
                chk("rr_ack_b", 32'(Ack_B), 32'(w == 1'b1));
                chk("rr_err", 32'(Err), 32'd0);
                chk("rr_rdata_a", RData_A, exp_rd[0]);
                chk("rr_rdata_b", RData_B, exp_rd[1]);
                chk("rr_resp_read", 32'(Mem_Read), 32'd0);
                w = !w;
                if (k == 2 * n) begin
                    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                end
            end
        end
        @(negedge Clk);
        chk_idle_outputs("rr_end");
        chk("rr_count", 32'(Num_Accesos), 32'(exp_cnt));
    endtask

    task automatic reset_model();
        lg = 1'b1;
        exp_cnt = 0;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        reset_model();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_idle_outputs("reset");
        chk("reset_err", 32'(Err), 32'd0);
        chk("reset_rdata", RData_A | RData_B, 32'd0);
        chk("reset_memaddr", 32'(Mem_Adress) | Mem_Write_Data, 32'd0);
        chk("reset_count", 32'(Num_Accesos), 32'd0);
        Rst_n = 1'b1;

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 32'h10, 32'd0);
        chk("t1_rdata", RData_A, 32'hDEADBEEF);
        chk("t1_count", 32'(Num_Accesos), 32'd2);

        for (int i = 0; i < 32; i++) txn(i[0], 1'b1, 32'(i * 4), $urandom);

        txn(1'b1, 1'b0, 32'h7E, 32'd0);
        txn(1'b1, 1'b0, 32'h80, 32'd0);
        chk("t3_rdata_b", RData_B, 32'd0);

        txn(1'b0, 1'b1, 32'h04, 32'hA5A55A5A);
        txn(1'b1, 1'b0, 32'h04, 32'd0);
        chk("t4_rdata_b", RData_B, 32'hA5A55A5A);

        both_reads(4);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 4);
            if (sel == 0)      ra = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) ra = 32'($urandom_range(32, 4000)) << 2;
            else               ra = 32'($urandom_range(0, 31)) << 2;
            if (i % 10 == 9) both_reads(2);
            else txn(1'(($urandom) % 2), 1'(($urandom) % 2), ra, $urandom);
        end
        chk("t6_saturated", 32'(Num_Accesos), 32'((1 << CW) - 1));

        // Reset during ACCESS aborts the access
        @(negedge Clk);
        drive(1'b0, 1'b1, 1'b0, 32'h08, 32'd0);
        @(negedge Clk);
        chk("t5_in_access", 32'(Mem_Read), 32'd1);
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge Clk);
        reset_model();
        chk_idle_outputs("t5_reset");
        chk("t5_err", 32'(Err), 32'd0);
        chk("t5_rdata", RData_A | RData_B, 32'd0);
        chk("t5_count", 32'(Num_Accesos), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("t5_no_late_ack");
        both_reads(2);

        for (int i = 0; i < 20; i++) txn(1'(i % 2), 1'b1, 32'($urandom_range(0, 31)) << 2, $urandom);
        chk("t6_sticks_at_max", 32'(Num_Accesos), 32'((1 << CW) - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
